// File: rtl/dm_access.sv
// dm_access: M-stage data-memory access unit with req/gnt/rvalid bus handshake.
// Ports: req_* upstream access, mem_* data bus, rsp_* completion, busy to hazard unit.
module dm_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_exc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t      state;
  state_t      state_nx;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  lat_a;

  logic        mis;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_req   = (state == REQ);
  assign rsp_valid = (state == DONE);

  // Reserved size falls into the word branch.
  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = req_addr[0];
      default: mis = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    st_be    = 4'hF;
    st_wdata = req_wdata;
    unique case (req_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_b   = mem_rdata[7:0];
    ld_h   = lat_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext = mem_rdata;
    unique case (lat_a)
      2'd0:    ld_b = mem_rdata[7:0];
      2'd1:    ld_b = mem_rdata[15:8];
      2'd2:    ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
    unique case (lat_size)
      SZ_BYTE: ld_ext = {{24{~lat_uns & ld_b[7]}}, ld_b};
      SZ_HALF: ld_ext = {{16{~lat_uns & ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_valid) state_nx = mis ? DONE : REQ;
      REQ:  if (mem_gnt) state_nx = lat_we ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_a     <= 2'b00;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_exc   <= 2'b00;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_size  <= req_size;
        lat_uns   <= req_unsigned;
        lat_a     <= req_addr[1:0];
        rsp_rdata <= 32'h0;
        if (mis) begin
          rsp_exc <= req_we ? 2'b10 : 2'b01;
        end else begin
          rsp_exc   <= 2'b00;
          mem_we    <= req_we;
          mem_be    <= req_we ? st_be : 4'hF;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= req_we ? st_wdata : 32'h0;
        end
      end
      if (state == REQ && mem_gnt) begin
        mem_we <= 1'b0;
        mem_be <= 4'h0;
      end
      if (state == WAIT && mem_rvalid) begin
        rsp_rdata <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// tb_dm_access: directed vector table plus reset-in-WAIT sequence for dm_access.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_dm_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_exc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_access dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_exc      (rsp_exc),
    .busy         (busy)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          rvdly;
    logic [1:0]  e_exc;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    chk({v.name, " ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    if (v.e_exc != 2'b00) begin
      chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({v.name, " exc"}, 32'(rsp_exc), 32'(v.e_exc));
      chk({v.name, " rdata"}, rsp_rdata, 32'h0);
      chk({v.name, " no mem_req"}, 32'(mem_req), 32'd0);
      @(negedge clk);
      chk({v.name, " no mem_req2"}, 32'(mem_req), 32'd0);
      chk({v.name, " pulse end"}, 32'(rsp_valid), 32'd0);
      chk({v.name, " exc hold"}, 32'(rsp_exc), 32'(v.e_exc));
      return;
    end
    for (int i = 0; i <= v.stall; i++) begin
      chk({v.name, " mem_req"}, 32'(mem_req), 32'd1);
      chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.we));
      chk({v.name, " mem_addr"}, mem_addr, v.e_addr);
      chk({v.name, " mem_be"}, 32'(mem_be), 32'(v.e_be));
      if (v.we) chk({v.name, " mem_wdata"}, mem_wdata, v.e_wdata);
      chk({v.name, " busy"}, 32'(busy), 32'd1);
      chk({v.name, " rsp early"}, 32'(rsp_valid), 32'd0);
      mem_gnt = (i == v.stall);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    chk({v.name, " req drop"}, 32'(mem_req), 32'd0);
    if (!v.we) begin
      for (int i = 0; i <= v.rvdly; i++) begin
        chk({v.name, " wait rsp"}, 32'(rsp_valid), 32'd0);
        chk({v.name, " wait busy"}, 32'(busy), 32'd1);
        mem_rvalid = (i == v.rvdly);
        mem_rdata  = (i == v.rvdly) ? v.rdata : 32'hDEAD_0000;
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0BAD_F00D;
    end
    chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({v.name, " exc"}, 32'(rsp_exc), 32'd0);
    chk({v.name, " rdata"}, rsp_rdata, v.e_rdata);
    @(negedge clk);
    chk({v.name, " pulse end"}, 32'(rsp_valid), 32'd0);
    chk({v.name, " rdata hold"}, rsp_rdata, v.e_rdata);
    chk({v.name, " idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tv[15];

  initial begin
    // name we size uns addr wdata rdata stall rvdly exc e_addr e_be e_wdata e_rdata
    tv[0]  = '{"sb3", 1, 2'b10, 0, 32'h1003, 32'h123456AB, 0, 0, 0,
               2'b00, 32'h1000, 4'b1000, 32'hABABABAB, 0};
    tv[1]  = '{"lb", 0, 2'b10, 0, 32'h2002, 0, 32'h11F02233, 0, 0,
               2'b00, 32'h2000, 4'hF, 0, 32'hFFFFFFF0};
    tv[2]  = '{"lbu", 0, 2'b10, 1, 32'h2002, 0, 32'h11F02233, 0, 0,
               2'b00, 32'h2000, 4'hF, 0, 32'h000000F0};
    tv[3]  = '{"lh", 0, 2'b01, 0, 32'h2002, 0, 32'h8001FFFF, 0, 0,
               2'b00, 32'h2000, 4'hF, 0, 32'hFFFF8001};
    tv[4]  = '{"lhu", 0, 2'b01, 1, 32'h2000, 0, 32'h8001FFFF, 0, 0,
               2'b00, 32'h2000, 4'hF, 0, 32'h0000FFFF};
    tv[5]  = '{"lw mis", 0, 2'b00, 0, 32'h3002, 0, 0, 0, 0,
               2'b01, 0, 0, 0, 0};
    tv[6]  = '{"sh mis", 1, 2'b01, 0, 32'h3001, 32'h1234, 0, 0, 0,
               2'b10, 0, 0, 0, 0};
    tv[7]  = '{"sw stall", 1, 2'b00, 0, 32'h4000, 32'hDEADBEEF, 0, 3, 0,
               2'b00, 32'h4000, 4'hF, 32'hDEADBEEF, 0};
    tv[8]  = '{"sh hi", 1, 2'b01, 0, 32'h5002, 32'hAAAA1234, 0, 1, 0,
               2'b00, 32'h5000, 4'b1100, 32'h12341234, 0};
    tv[9]  = '{"lw slow", 0, 2'b00, 0, 32'h6004, 0, 32'h87654321, 1, 2,
               2'b00, 32'h6004, 4'hF, 0, 32'h87654321};
    tv[10] = '{"lb pos", 0, 2'b10, 0, 32'h7001, 0, 32'h00007F00, 0, 0,
               2'b00, 32'h7000, 4'hF, 0, 32'h0000007F};
    tv[11] = '{"rsv mis", 0, 2'b11, 0, 32'h8002, 0, 0, 0, 0,
               2'b01, 0, 0, 0, 0};
    tv[12] = '{"sb0", 1, 2'b10, 0, 32'h9000, 32'h000000FF, 0, 0, 0,
               2'b00, 32'h9000, 4'b0001, 32'hFFFFFFFF, 0};
    tv[13] = '{"lb b3", 0, 2'b10, 0, 32'hA003, 0, 32'h80FFFFFF, 0, 1,
               2'b00, 32'hA000, 4'hF, 0, 32'hFFFFFF80};
    tv[14] = '{"sh lo", 1, 2'b01, 0, 32'hB000, 32'h0000C3C3, 0, 0, 0,
               2'b00, 32'hB000, 4'b0011, 32'hC3C3C3C3, 0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    #2;
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_be", 32'(mem_be), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst ready", 32'(req_ready), 1);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run(tv[i]);

    // Reset while a load sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'hC000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw mem_req", 32'(mem_req), 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw in wait", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("rw rst mem_req", 32'(mem_req), 0);
    chk("rw rst mem_be", 32'(mem_be), 0);
    chk("rw rst mem_we", 32'(mem_we), 0);
    chk("rw rst mem_addr", mem_addr, 0);
    chk("rw rst mem_wdata", mem_wdata, 0);
    chk("rw rst busy", 32'(busy), 0);
    chk("rw rst ready", 32'(req_ready), 1);
    chk("rw rst rsp_valid", 32'(rsp_valid), 0);
    chk("rw rst rdata", rsp_rdata, 0);
    chk("rw rst exc", 32'(rsp_exc), 0);
    @(negedge clk);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rw stale rsp", 32'(rsp_valid), 0);
    chk("rw stale busy", 32'(busy), 0);
    @(negedge clk);
    chk("rw stale rsp2", 32'(rsp_valid), 0);
    chk("rw stale rdata", rsp_rdata, 0);
    run('{"lw after rst", 0, 2'b00, 0, 32'hC000, 0, 32'hCAFEBABE, 0, 0,
          2'b00, 32'hC000, 4'hF, 0, 32'hCAFEBABE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_access.md
# dm_access

Data-memory access unit for the five-stage pipeline's M stage. It is the memory-side counterpart of the D-stage immediate extender:
- On stores, it narrows and aligns 32-bit register data into byte-lane writes with byte enables.
- On loads, it selects the addressed lane of returned memory data and sign- or zero-extends it back to 32 bits.

It runs a request/grant/response handshake with the data bus and holds `busy` so the hazard unit can stall the pipeline until the access completes.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — the single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — M stage presents an access.
- `req_ready` out 1 — unit can accept an access (state IDLE).
- `req_we` in 1 — 1 = store, 0 = load.
- `req_size` in 2 — 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `req_unsigned` in 1 — loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data; the low byte or half is used for narrow stores.
- `mem_req` out 1 — bus request.
- `mem_we` out 1 — bus write.
- `mem_addr` out 32 — word address; bits [1:0] are always 0.
- `mem_be` out 4 — byte enables; bit i covers bits [8i+7:8i].
- `mem_wdata` out 32 — lane-replicated store data.
- `mem_gnt` in 1 — bus accepts the request this cycle.
- `mem_rvalid` in 1 — read data valid.
- `mem_rdata` in 32 — read data.
- `rsp_valid` out 1 — one-cycle completion pulse.
- `rsp_rdata` out 32 — extended load result; 0 for stores and exceptions.
- `rsp_exc` out 2 — 00 none, 01 AdEL (misaligned load), 10 AdES (misaligned store).
- `busy` out 1 — high whenever state is not IDLE.

## Operation
States: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_size`, `req_unsigned`, `req_addr`[1:0].
  - Misaligned access (half with addr[0]=1, or word/reserved with addr[1:0]≠00): no bus access; set `rsp_exc` (AdEL or AdES by `req_we`); go DONE.
  - Otherwise drive the registered bus fields and go REQ.
- **REQ**
  - `mem_req`=1; `mem_addr`, `mem_be`, `mem_wdata`, `mem_we` stay stable until `mem_gnt`.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT. Clear `mem_req`/`mem_we`/`mem_be` on leaving REQ.
- **WAIT**
  - `mem_rvalid` is sampled only in this state, so the earliest is the cycle after `mem_gnt`.
  - On `mem_rvalid`, register the extended `rsp_rdata` and go DONE.
- **DONE**
  - `rsp_valid`=1 for exactly one cycle, then IDLE.
  - `rsp_rdata`/`rsp_exc` hold until the next access is accepted.

Store lane rules (a = addr[1:0]):
- byte: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=0001<<a.
- half: `mem_wdata`={2{wdata[15:0]}}, `mem_be`= 1100 if a[1] else 0011.
- word: `mem_wdata`=wdata, `mem_be`=1111.

Load lane rules:
- byte: selects `mem_rdata`[8a+7:8a].
- half: selects [31:16] if a[1] else [15:0].
- The selected field is extended from its msb unless `req_unsigned`; word loads pass through.
- Loads drive `mem_be`=1111 regardless of size.

## Timing
- Reset (async, immediate) sets:
  - state IDLE;
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` = 0;
  - `rsp_valid`, `rsp_rdata`, `rsp_exc` = 0;
  - `busy`=0, `req_ready`=1.
- Accept at edge 0. `mem_req` is visible during cycle 1.
- With `mem_gnt` in cycle 1:
  - a store's `rsp_valid` is in cycle 2;
  - a load with `mem_rvalid` in cycle 2 has `rsp_valid` in cycle 3.
- Bus waits add one cycle per stalled cycle.
- A misaligned access has `rsp_valid` in cycle 1 and `mem_req` never rises.
- `req_valid` outside IDLE is ignored; upstream must hold it until `req_ready`.
- A new access can be accepted in the cycle after DONE, so back-to-back accesses have a 1-cycle IDLE gap.
- `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.
- Reset asserted mid-access (REQ or WAIT) drops `mem_req` immediately and no `rsp_valid` is produced. The bus owner must discard any in-flight response.

## Test plan
- **Narrow store**: sb, `req_addr`=0x1003, `req_wdata`=0x123456AB, `mem_gnt` held high.
  - Cycle 1: `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_we`=1.
  - Cycle 2: `rsp_valid`=1, `rsp_exc`=00.
- **Signed byte load**: lb, addr=0x2002, `mem_rdata`=0x11F02233 in WAIT → `rsp_rdata`=0xFFFFFFF0. Repeated as lbu → 0x000000F0.
- **Half load**: lh, addr=0x2002, `mem_rdata`=0x8001FFFF → 0xFFFF8001. lhu, addr=0x2000, same data → 0x0000FFFF.
- **Misaligned accesses**:
  - lw at 0x3002 → `rsp_valid` in cycle 1, `rsp_exc`=01, `mem_req` never rises.
  - sh at 0x3001 → `rsp_exc`=10.
- **Bus stall**: sw with `mem_gnt` low for 3 cycles.
  - `mem_addr`, `mem_be`, `mem_wdata` stable throughout; `busy`=1.
  - `rsp_valid` exactly one cycle after the grant cycle.
- **Reset in WAIT**: lw granted, then `reset` pulsed before `mem_rvalid`.
  - All outputs at reset values immediately.
  - A later `mem_rvalid` produces no `rsp_valid`.
  - A subsequent lw completes normally.
